// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: FSM encodings, frame
// direction bit values and the frame-length helper.
package spi_reg_bank_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a history flop
// giving single-cycle rise/fall pulses in the clk_sys domain.
module spi_sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register-file peripheral: oversampled SPI pins, command/data
// framing FSM, write commit on chip-select release and CIPO readback.
//
// state   | meaning
// IDLE    | waiting for chip select to fall
// CMD     | shifting rw + address bits
// DATA    | shifting data bits; driving CIPO for reads
module spi_reg_bank
   import spi_reg_bank_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 5,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sclk,
   input  logic                         ncs,
   input  logic                         copi,
   output logic                         cipo,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_out,
   output logic                         wr_pulse,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err
);

   localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(ADDR_W);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ncs_lvl, ncs_rise, ncs_fall;
   logic copi_s, copi_rise, copi_fall;
   logic unused_sync;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   // Chip select idles high, so a frame already in progress at reset release
   // still shows up as a falling edge.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .din(ncs),
      .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .din(copi),
      .level(copi_s), .rise(copi_rise), .fall(copi_fall));

   assign unused_sync = sclk_lvl ^ ncs_lvl ^ copi_rise ^ copi_fall;

   logic [1:0]                  state_q;
   logic [CNT_W-1:0]            bit_cnt_q;
   logic [FRAME_W-1:0]          shift_q;
   logic [DATA_W-1:0]           shadow_q;
   logic [NUM_REGS*DATA_W-1:0]  regs_q;
   logic                        cipo_q, cipo_oe_q, wr_pulse_q, frame_err_q;
   logic [ADDR_W-1:0]           wr_addr_q;

   logic                frame_rw;
   logic [ADDR_W-1:0]   frame_addr;
   logic [DATA_W-1:0]   frame_data;
   logic                frame_in_range;
   logic [ADDR_W:0]     cmd_next;
   logic [DATA_W-1:0]   rd_sel;
   logic                commit, bad_len;

   assign frame_rw       = shift_q[FRAME_W-1];
   assign frame_addr     = shift_q[FRAME_W-2 -: ADDR_W];
   assign frame_data     = shift_q[DATA_W-1:0];
   assign frame_in_range = 32'(frame_addr) < NUM_REGS;
   assign cmd_next       = {shift_q[ADDR_W-1:0], copi_s};

   assign commit  = ncs_rise && (frame_rw == RW_WRITE) && (bit_cnt_q == CNT_FRAME) && frame_in_range;
   assign bad_len = ncs_rise && (bit_cnt_q != CNT_FRAME) && (bit_cnt_q != '0);

   // Unimplemented addresses read as zero.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (32'(cmd_next[ADDR_W-1:0]) == i) rd_sel = regs_q[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         shadow_q    <= '0;
         regs_q      <= '0;
         cipo_q      <= 1'b0;
         cipo_oe_q   <= 1'b0;
         wr_pulse_q  <= 1'b0;
         wr_addr_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         wr_pulse_q  <= commit;
         frame_err_q <= bad_len;
         if (commit) begin
            wr_addr_q <= frame_addr;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (32'(frame_addr) == i) regs_q[i*DATA_W +: DATA_W] <= frame_data;
            end
         end

         // A chip-select release pre-empts any SCLK edge seen in the same cycle.
         if (ncs_rise) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (ncs_fall) begin
                     state_q   <= ST_CMD;
                     bit_cnt_q <= '0;
                  end
               end
               ST_CMD: begin
                  if (sclk_rise) begin
                     shift_q   <= {shift_q[FRAME_W-2:0], copi_s};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == CNT_CMD_LAST) begin
                        state_q   <= ST_DATA;
                        cipo_oe_q <= (cmd_next[ADDR_W] == RW_READ);
                        shadow_q  <= (cmd_next[ADDR_W] == RW_READ) ? rd_sel : '0;
                     end
                  end
               end
               ST_DATA: begin
                  if (sclk_rise) begin
                     shift_q <= {shift_q[FRAME_W-2:0], copi_s};
                     if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
                  if (sclk_fall && cipo_oe_q) begin
                     cipo_q   <= shadow_q[DATA_W-1];
                     shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign cipo      = cipo_q;
   assign cipo_oe   = cipo_oe_q;
   assign regs_out  = regs_q;
   assign wr_pulse  = wr_pulse_q;
   assign wr_addr   = wr_addr_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: default-parameter instance plus a wide
// instance clocked at the SCLK limit.
module tb_spi_reg_bank;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic sclk0 = 1'b0, ncs0 = 1'b1, copi0 = 1'b0;
   logic cipo0, cipo_oe0, wr_pulse0, frame_err0;
   logic [39:0] regs_out0;
   logic [6:0]  wr_addr0;

   logic sclk1 = 1'b0, ncs1 = 1'b1, copi1 = 1'b0;
   logic cipo1, cipo_oe1, wr_pulse1, frame_err1;
   logic [255:0] regs_out1;
   logic [3:0]   wr_addr1;

   spi_reg_bank dut0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk0), .ncs(ncs0), .copi(copi0),
      .cipo(cipo0), .cipo_oe(cipo_oe0), .regs_out(regs_out0),
      .wr_pulse(wr_pulse0), .wr_addr(wr_addr0), .frame_err(frame_err0));

   spi_reg_bank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk1), .ncs(ncs1), .copi(copi1),
      .cipo(cipo1), .cipo_oe(cipo_oe1), .regs_out(regs_out1),
      .wr_pulse(wr_pulse1), .wr_addr(wr_addr1), .frame_err(frame_err1));

   int wr_cnt0 = 0, err_cnt0 = 0, wr_cnt1 = 0, err_cnt1 = 0;
   always @(negedge clk) begin
      if (wr_pulse0)  wr_cnt0  <= wr_cnt0 + 1;
      if (frame_err0) err_cnt0 <= err_cnt0 + 1;
      if (wr_pulse1)  wr_cnt1  <= wr_cnt1 + 1;
      if (frame_err1) err_cnt1 <= err_cnt1 + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_pins(input int sel, input logic s, input logic n, input logic c);
      if (sel == 0) begin sclk0 = s; ncs0 = n; copi0 = c; end
      else          begin sclk1 = s; ncs1 = n; copi1 = c; end
   endtask

   task automatic begin_frame(input int sel, input int half);
      set_pins(sel, 1'b0, 1'b0, 1'b0);
      wait_clk(half);
   endtask

   task automatic end_frame(input int sel, input int half);
      wait_clk(half);
      set_pins(sel, 1'b0, 1'b1, 1'b0);
      wait_clk(12);
   endtask

   // Shifts nbits of frame MSB first; CIPO and CIPO_OE are sampled at the end
   // of each SCLK high phase.
   task automatic shift_bits(input int sel, input int nbits, input logic [31:0] frame,
                             input int half, output logic [31:0] rx, output logic [31:0] oe);
      rx = '0;
      oe = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         set_pins(sel, 1'b0, 1'b0, frame[i]);
         wait_clk(half);
         set_pins(sel, 1'b1, 1'b0, frame[i]);
         wait_clk(half);
         rx[i] = (sel == 0) ? cipo0 : cipo1;
         oe[i] = (sel == 0) ? cipo_oe0 : cipo_oe1;
         set_pins(sel, 1'b0, 1'b0, frame[i]);
      end
   endtask

   task automatic xfer(input int sel, input int nbits, input logic [31:0] frame, input int half,
                       output logic [31:0] rx, output logic [31:0] oe);
      begin_frame(sel, half);
      shift_bits(sel, nbits, frame, half, rx, oe);
      end_frame(sel, half);
   endtask

   logic [31:0] rx, oe;
   int w0, e0, w1, e1;

   initial begin
      // Reset state
      wait_clk(5);
      chk("rst_regs", regs_out0, '0);
      chk("rst_outs", {cipo0, cipo_oe0, wr_pulse0, wr_addr0, frame_err0}, '0);
      rst_n = 1'b1;
      wait_clk(5);

      // Write 0xA5 to addr 2
      w0 = wr_cnt0; e0 = err_cnt0;
      xfer(0, 16, 32'h82A5, 4, rx, oe);
      chk("wr2_regs", regs_out0, 40'h00_00_A5_00_00);
      chk("wr2_pulse", 32'(wr_cnt0 - w0), 1);
      chk("wr2_addr", wr_addr0, 7'd2);
      chk("wr2_noerr", 32'(err_cnt0 - e0), 0);

      // Write 0x3C to addr 4, read it back
      xfer(0, 16, 32'h843C, 4, rx, oe);
      chk("wr4_regs", regs_out0, 40'h3C_00_A5_00_00);
      w0 = wr_cnt0;
      xfer(0, 16, 32'h0400, 4, rx, oe);
      chk("rd4_data", rx[7:0], 8'h3C);
      chk("rd4_oe_cmd", oe[15:9], 7'h00);
      chk("rd4_oe_data", oe[7:0], 8'hFF);
      chk("rd4_nopulse", 32'(wr_cnt0 - w0), 0);
      chk("rd4_oe_idle", {cipo_oe0, cipo0}, 2'b00);
      chk("rd4_regs", regs_out0, 40'h3C_00_A5_00_00);
      xfer(0, 16, 32'h0200, 4, rx, oe);
      chk("rd2_data", rx[7:0], 8'hA5);

      // Short and long writes to addr 1
      w0 = wr_cnt0; e0 = err_cnt0;
      xfer(0, 15, 32'h8177 >> 1, 4, rx, oe);
      chk("short_err", 32'(err_cnt0 - e0), 1);
      xfer(0, 17, 32'h8177 << 1, 4, rx, oe);
      chk("long_err", 32'(err_cnt0 - e0), 2);
      chk("badlen_nopulse", 32'(wr_cnt0 - w0), 0);
      chk("badlen_regs", regs_out0, 40'h3C_00_A5_00_00);

      // Out-of-range address
      w0 = wr_cnt0; e0 = err_cnt0;
      xfer(0, 16, 32'h87FF, 4, rx, oe);
      chk("oor_regs", regs_out0, 40'h3C_00_A5_00_00);
      chk("oor_nopulse", 32'(wr_cnt0 - w0), 0);
      chk("oor_noerr", 32'(err_cnt0 - e0), 0);
      xfer(0, 16, 32'h0700, 4, rx, oe);
      chk("oor_rd", rx[7:0], 8'h00);

      // Chip-select pulse without SCLK is silent
      e0 = err_cnt0;
      begin_frame(0, 4);
      end_frame(0, 4);
      chk("empty_noerr", 32'(err_cnt0 - e0), 0);

      // Reset after 9 bits of a write of 0x55 to addr 2, then finish the frame
      w0 = wr_cnt0; e0 = err_cnt0;
      begin_frame(0, 4);
      shift_bits(0, 9, 32'h8255 >> 7, 4, rx, oe);
      rst_n = 1'b0;
      wait_clk(4);
      chk("midrst_regs", regs_out0, '0);
      rst_n = 1'b1;
      wait_clk(4);
      shift_bits(0, 7, 32'h55, 4, rx, oe);
      end_frame(0, 4);
      chk("midrst_regs_after", regs_out0, '0);
      chk("midrst_err", 32'(err_cnt0 - e0), 1);
      chk("midrst_nopulse", 32'(wr_cnt0 - w0), 0);

      // Wide instance at SCLK = clk/4
      w1 = wr_cnt1; e1 = err_cnt1;
      xfer(1, 21, 32'h1FBEEF, 2, rx, oe);
      chk("w_regs_hi", regs_out1[255:240], 16'hBEEF);
      chk("w_regs_lo", regs_out1[239:0], '0);
      chk("w_pulse", 32'(wr_cnt1 - w1), 1);
      chk("w_addr", wr_addr1, 4'hF);
      xfer(1, 21, 32'h0F0000, 2, rx, oe);
      chk("w_rd", rx[15:0], 16'hBEEF);
      chk("w_noerr", 32'(err_cnt1 - e1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
